// File: rtl/core_pkg.sv
// Shared definitions for the core memory sequencer: default geometry and FSM encodings.
package core_pkg;

    localparam int unsigned RowDef    = 8;
    localparam int unsigned ColDef    = 8;
    localparam int unsigned XaddrWDef = 11;
    localparam int unsigned PaddrWDef = 11;
    localparam int unsigned KijWDef   = 4;
    localparam int unsigned NvecWDef  = 7;

    // Sequencer states, kept as plain constants for compatibility with older tools.
    localparam int unsigned StateW = 3;
    localparam logic [StateW-1:0] StIdle    = 3'd0;
    localparam logic [StateW-1:0] StLoadW   = 3'd1;
    localparam logic [StateW-1:0] StLoadA   = 3'd2;
    localparam logic [StateW-1:0] StDrainRd = 3'd3;
    localparam logic [StateW-1:0] StDrainWr = 3'd4;
    localparam logic [StateW-1:0] StDone    = 3'd5;

endpackage

// File: rtl/seq_addr_ctr.sv
// Loadable address counter: base + offset, with a terminal-count flag.
// addr_nxt_o is the address the counter will hold after the coming edge, so the
// caller can register it in step with the state that uses it.
module seq_addr_ctr #(
    parameter int unsigned AddrW = 11,
    parameter int unsigned CntW  = 7
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [AddrW-1:0] base_i,
    input  logic [CntW-1:0]  last_i,
    output logic [AddrW-1:0] addr_nxt_o,
    output logic             tc_o
);

    logic [AddrW-1:0] base_q, base_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Load restarts the offset at zero; increment steps it.
    always_comb begin
        base_d = base_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            base_d = base_i;
            cnt_d  = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
        addr_nxt_o = base_d + AddrW'(cnt_d);
        tc_o       = (cnt_q == last_i);
    end

    // Counter state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            base_q <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/core_mem_seq.sv
// Autonomous xmem/pmem sequencer: per kij, load ROW weights, stream n_vec
// activations, then drain the OFIFO with a read-modify-write into pmem.
// All outputs are flops loaded from the next-state decode.
module core_mem_seq
    import core_pkg::*;
#(
    parameter int unsigned ROW     = RowDef,
    parameter int unsigned COL     = ColDef,
    parameter int unsigned XADDR_W = XaddrWDef,
    parameter int unsigned PADDR_W = PaddrWDef,
    parameter int unsigned KIJ_W   = KijWDef,
    parameter int unsigned NVEC_W  = NvecWDef
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [XADDR_W-1:0] w_base,
    input  logic [XADDR_W-1:0] a_base,
    input  logic [PADDR_W-1:0] p_base,
    input  logic [KIJ_W-1:0]   n_kij,
    input  logic [NVEC_W-1:0]  n_vec,
    input  logic               ofifo_valid,
    output logic               CEN_xmem,
    output logic               WEN_xmem,
    output logic [XADDR_W-1:0] A_xmem,
    output logic               CEN_pmem,
    output logic               WEN_pmem,
    output logic [PADDR_W-1:0] A_pmem,
    output logic               l0_wr,
    output logic               load_w,
    output logic               ofifo_rd,
    output logic               acc_clr,
    output logic               busy,
    output logic               done
);

    // The weight index shares the n_vec-wide counter.
    if (ROW < 1 || COL < 1 || ROW > (1 << NVEC_W)) begin : g_bad_cfg
        $error("core_mem_seq: ROW/COL out of range");
    end

    logic [StateW-1:0]  state_q, state_d;
    logic [KIJ_W-1:0]   kij_q, kij_d, n_kij_q, n_kij_d;
    logic [NVEC_W-1:0]  n_vec_q, n_vec_d;
    logic [XADDR_W-1:0] w_base_q, w_base_d, a_base_q, a_base_d;
    logic [PADDR_W-1:0] p_base_q, p_base_d;
    logic               rd_go_q, rd_go_d;  // OFIFO seen valid: RD slot issued this cycle

    logic               x_load, x_inc, x_tc, p_load, p_inc, p_tc;
    logic [XADDR_W-1:0] x_base, x_addr_nxt;
    logic [PADDR_W-1:0] p_addr_nxt;
    logic [NVEC_W-1:0]  x_last;

    logic               cen_xmem_q, cen_xmem_d, cen_pmem_q, cen_pmem_d, wen_pmem_q, wen_pmem_d;
    logic [XADDR_W-1:0] a_xmem_q, a_xmem_d;
    logic [PADDR_W-1:0] a_pmem_q, a_pmem_d;
    logic               l0_wr_q, l0_wr_d, load_w_q, load_w_d, ofifo_rd_q, ofifo_rd_d;
    logic               acc_clr_q, acc_clr_d, busy_q, busy_d, done_q, done_d;
    logic               rd_slot, wr_slot;

    assign x_last = (state_q == StLoadW) ? NVEC_W'(ROW - 1) : n_vec_q - NVEC_W'(1);

    seq_addr_ctr #(.AddrW(XADDR_W), .CntW(NVEC_W)) u_xmem_ctr (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (x_load),
        .inc_i      (x_inc),
        .base_i     (x_base),
        .last_i     (x_last),
        .addr_nxt_o (x_addr_nxt),
        .tc_o       (x_tc)
    );

    seq_addr_ctr #(.AddrW(PADDR_W), .CntW(NVEC_W)) u_pmem_ctr (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (p_load),
        .inc_i      (p_inc),
        .base_i     (p_base_q),
        .last_i     (n_vec_q - NVEC_W'(1)),
        .addr_nxt_o (p_addr_nxt),
        .tc_o       (p_tc)
    );

    // Next-state, config latch and address-counter control.
    always_comb begin
        state_d  = state_q;
        kij_d    = kij_q;
        n_kij_d  = n_kij_q;
        n_vec_d  = n_vec_q;
        w_base_d = w_base_q;
        a_base_d = a_base_q;
        p_base_d = p_base_q;
        rd_go_d  = 1'b0;
        x_load   = 1'b0;
        x_inc    = 1'b0;
        x_base   = w_base;
        p_load   = 1'b0;
        p_inc    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    n_kij_d  = n_kij;
                    n_vec_d  = n_vec;
                    w_base_d = w_base;
                    a_base_d = a_base;
                    p_base_d = p_base;
                    kij_d    = '0;
                    x_load   = 1'b1;
                    state_d  = (n_kij == '0 || n_vec == '0) ? StDone : StLoadW;
                end
            end
            StLoadW: begin
                if (x_tc) begin
                    state_d = StLoadA;
                    x_load  = 1'b1;
                    x_base  = a_base_q;
                end else begin
                    x_inc = 1'b1;
                end
            end
            StLoadA: begin
                if (x_tc) begin
                    state_d = StDrainRd;
                    p_load  = 1'b1;
                    rd_go_d = ofifo_valid;
                end else begin
                    x_inc = 1'b1;
                end
            end
            StDrainRd: begin
                // Hold the slot idle until the OFIFO has a row to pop.
                if (rd_go_q) begin
                    state_d = StDrainWr;
                end else begin
                    rd_go_d = ofifo_valid;
                end
            end
            StDrainWr: begin
                if (!p_tc) begin
                    state_d = StDrainRd;
                    p_inc   = 1'b1;
                    rd_go_d = ofifo_valid;
                end else if (kij_q == n_kij_q - KIJ_W'(1)) begin
                    state_d = StDone;
                end else begin
                    kij_d   = kij_q + KIJ_W'(1);
                    state_d = StLoadW;
                    x_load  = 1'b1;
                    // kij*ROW deliberately truncated to the xmem address width.
                    x_base  = w_base_q + XADDR_W'(kij_d) * XADDR_W'(ROW);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the state being entered, so outputs line up with it.
    always_comb begin
        rd_slot    = (state_d == StDrainRd) && rd_go_d;
        wr_slot    = (state_d == StDrainWr);
        cen_xmem_d = !((state_d == StLoadW) || (state_d == StLoadA));
        a_xmem_d   = cen_xmem_d ? '0 : x_addr_nxt;
        l0_wr_d    = !cen_xmem_q;
        load_w_d   = (state_q == StLoadW);
        cen_pmem_d = !(rd_slot || wr_slot);
        wen_pmem_d = !wr_slot;
        a_pmem_d   = (rd_slot || wr_slot) ? p_addr_nxt : '0;
        ofifo_rd_d = rd_slot;
        acc_clr_d  = rd_slot && (kij_d == '0);
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
    end

    // State and registered outputs; reset abandons any slot in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            kij_q      <= '0;
            n_kij_q    <= '0;
            n_vec_q    <= '0;
            w_base_q   <= '0;
            a_base_q   <= '0;
            p_base_q   <= '0;
            rd_go_q    <= 1'b0;
            cen_xmem_q <= 1'b1;
            a_xmem_q   <= '0;
            cen_pmem_q <= 1'b1;
            wen_pmem_q <= 1'b1;
            a_pmem_q   <= '0;
            l0_wr_q    <= 1'b0;
            load_w_q   <= 1'b0;
            ofifo_rd_q <= 1'b0;
            acc_clr_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kij_q      <= kij_d;
            n_kij_q    <= n_kij_d;
            n_vec_q    <= n_vec_d;
            w_base_q   <= w_base_d;
            a_base_q   <= a_base_d;
            p_base_q   <= p_base_d;
            rd_go_q    <= rd_go_d;
            cen_xmem_q <= cen_xmem_d;
            a_xmem_q   <= a_xmem_d;
            cen_pmem_q <= cen_pmem_d;
            wen_pmem_q <= wen_pmem_d;
            a_pmem_q   <= a_pmem_d;
            l0_wr_q    <= l0_wr_d;
            load_w_q   <= load_w_d;
            ofifo_rd_q <= ofifo_rd_d;
            acc_clr_q  <= acc_clr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign CEN_xmem = cen_xmem_q;
    assign WEN_xmem = 1'b1;  // xmem is read-only from this block
    assign A_xmem   = a_xmem_q;
    assign CEN_pmem = cen_pmem_q;
    assign WEN_pmem = wen_pmem_q;
    assign A_pmem   = a_pmem_q;
    assign l0_wr    = l0_wr_q;
    assign load_w   = load_w_q;
    assign ofifo_rd = ofifo_rd_q;
    assign acc_clr  = acc_clr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
